// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline and pipe_ctrl.
// master: pipeline side (drives requests, receives controls).
// slave : pipe_ctrl (receives requests, drives controls and counters).
// Parameter CNT_W sets the width of the two performance counters.

`ifndef InstrAddrBus
`define InstrAddrBus 31:0
`endif

interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic                 id_stallreq_i_CTRL;
  logic                 ex_stallreq_i_CTRL;
  logic                 ex_done_i_CTRL;
  logic                 jump_req_i_CTRL;
  logic [`InstrAddrBus] jump_addr_i_CTRL;
  logic                 hold_pc_o_CTRL;
  logic                 hold_ifid_o_CTRL;
  logic                 hold_idex_o_CTRL;
  logic                 flush_ifid_o_CTRL;
  logic                 flush_idex_o_CTRL;
  logic                 flush_exmem_o_CTRL;
  logic                 jump_en_o_CTRL;
  logic [`InstrAddrBus] jump_addr_o_CTRL;
  logic [CNT_W-1:0]     stall_cnt_o_CTRL;
  logic [CNT_W-1:0]     flush_cnt_o_CTRL;

  modport master (
    output id_stallreq_i_CTRL, ex_stallreq_i_CTRL, ex_done_i_CTRL,
           jump_req_i_CTRL, jump_addr_i_CTRL,
    input  hold_pc_o_CTRL, hold_ifid_o_CTRL, hold_idex_o_CTRL,
           flush_ifid_o_CTRL, flush_idex_o_CTRL, flush_exmem_o_CTRL,
           jump_en_o_CTRL, jump_addr_o_CTRL, stall_cnt_o_CTRL, flush_cnt_o_CTRL
  );

  modport slave (
    input  id_stallreq_i_CTRL, ex_stallreq_i_CTRL, ex_done_i_CTRL,
           jump_req_i_CTRL, jump_addr_i_CTRL,
    output hold_pc_o_CTRL, hold_ifid_o_CTRL, hold_idex_o_CTRL,
           flush_ifid_o_CTRL, flush_idex_o_CTRL, flush_exmem_o_CTRL,
           jump_en_o_CTRL, jump_addr_o_CTRL, stall_cnt_o_CTRL, flush_cnt_o_CTRL
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage core.
// Arbitrates ID load-use stalls, EX multicycle stalls and EX redirects, and
// drives hold/flush for PC, IF_ID, ID_EX, EX_MEM plus the PC redirect.
// Ports:
//   clk_i_CTRL  - core clock, rising edge
//   rst_i_CTRL  - synchronous reset, asserted level `RstEnable
//   bus         - pipe_ctrl_if.slave: requests in, controls/counters out
// Parameters: FLUSH_CYCLES (1..15) flush length per redirect, CNT_W counter width.
// Optional feature macro: PIPE_CTRL_PERF_EN builds saturating stall/redirect
// counters; when undefined both counter outputs are tied to zero.

`ifndef InstrAddrBus
`define InstrAddrBus 31:0
`endif
`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef CpuRstAddr
`define CpuRstAddr 32'h0000_0000
`endif

module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input logic        clk_i_CTRL,
  input logic        rst_i_CTRL,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned FCNT_W      = 4;
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam bit          MULTI_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXSTALL = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [FCNT_W-1:0]    fcnt, fcnt_nxt;
  logic [`InstrAddrBus] target, target_nxt;

  logic                 rst_act;
  logic                 hold_pc, hold_ifid, hold_idex;
  logic                 flush_ifid, flush_idex, flush_exmem;
  logic                 jump_en;
  logic [`InstrAddrBus] jump_addr;

  assign rst_act = (rst_i_CTRL == `RstEnable);

  // Controls are combinational from state and current requests; reset masks them.
  always_comb begin
    hold_pc     = 1'b0;
    hold_ifid   = 1'b0;
    hold_idex   = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = target;
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    target_nxt  = target;

    if (rst_act) begin
      jump_addr  = `CpuRstAddr;
      state_nxt  = IDLE;
      fcnt_nxt   = '0;
      target_nxt = `CpuRstAddr;
    end else begin
      case (state)
        IDLE: begin
          if (bus.jump_req_i_CTRL) begin
            jump_en    = 1'b1;
            jump_addr  = bus.jump_addr_i_CTRL;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            target_nxt = bus.jump_addr_i_CTRL;
            state_nxt  = MULTI_FLUSH ? FLUSH : IDLE;
            fcnt_nxt   = MULTI_FLUSH ? FCNT_RELOAD : '0;
          end else if (bus.ex_stallreq_i_CTRL) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            hold_idex   = 1'b1;
            flush_exmem = 1'b1;
            // A same-cycle done is a zero-length stall: one held cycle only.
            state_nxt   = bus.ex_done_i_CTRL ? IDLE : EXSTALL;
          end else if (bus.id_stallreq_i_CTRL) begin
            hold_pc    = 1'b1;
            hold_ifid  = 1'b1;
            flush_idex = 1'b1;
          end
        end

        EXSTALL: begin
          // Holds stay up through the ex_done cycle; other requests wait.
          hold_pc     = 1'b1;
          hold_ifid   = 1'b1;
          hold_idex   = 1'b1;
          flush_exmem = 1'b1;
          if (bus.ex_done_i_CTRL) begin
            state_nxt = IDLE;
          end
        end

        FLUSH: begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (bus.jump_req_i_CTRL) begin
            // A new redirect restarts the flush window from this cycle.
            jump_en    = 1'b1;
            jump_addr  = bus.jump_addr_i_CTRL;
            target_nxt = bus.jump_addr_i_CTRL;
            state_nxt  = MULTI_FLUSH ? FLUSH : IDLE;
            fcnt_nxt   = MULTI_FLUSH ? FCNT_RELOAD : '0;
          end else begin
            fcnt_nxt = fcnt - FCNT_W'(1);
            if (fcnt == FCNT_W'(1)) begin
              state_nxt = IDLE;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          fcnt_nxt  = '0;
        end
      endcase
    end
  end

  // State, flush counter and latched redirect target.
  always_ff @(posedge clk_i_CTRL) begin
    state  <= state_nxt;
    fcnt   <= fcnt_nxt;
    target <= target_nxt;
  end

  assign bus.hold_pc_o_CTRL     = hold_pc;
  assign bus.hold_ifid_o_CTRL   = hold_ifid;
  assign bus.hold_idex_o_CTRL   = hold_idex;
  assign bus.flush_ifid_o_CTRL  = flush_ifid;
  assign bus.flush_idex_o_CTRL  = flush_idex;
  assign bus.flush_exmem_o_CTRL = flush_exmem;
  assign bus.jump_en_o_CTRL     = jump_en;
  assign bus.jump_addr_o_CTRL   = jump_addr;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating counters of held-PC cycles and redirects.
  always_ff @(posedge clk_i_CTRL) begin
    if (rst_act) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_pc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (jump_en && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt_o_CTRL = stall_cnt;
  assign bus.flush_cnt_o_CTRL = flush_cnt;
`else
  assign bus.stall_cnt_o_CTRL = CNT_W'(0);
  assign bus.flush_cnt_o_CTRL = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with FLUSH_CYCLES=3. A behavioural model
// tracks "cycles of stall pending" and "flush cycles left" and predicts every
// control, the redirect address and the counters each cycle.

`ifndef InstrAddrBus
`define InstrAddrBus 31:0
`endif
`ifndef CpuRstAddr
`define CpuRstAddr 32'h0000_0000
`endif

module tb_pipe_ctrl;

  localparam int unsigned FC    = 3;
  localparam int unsigned CW    = 32;
  localparam int unsigned VW    = 7 + 32 + 2 * CW;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i_CTRL (clk),
    .rst_i_CTRL (rst),
    .bus        (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model state
  bit          m_stalling   = 1'b0;
  int          m_flush_left = 0;
  logic [31:0] m_target     = `CpuRstAddr;
  logic [CW-1:0] m_scnt     = '0;
  logic [CW-1:0] m_fcnt     = '0;
  bit          n_stalling;
  int          n_flush_left;
  logic [31:0] n_target;
  logic [CW-1:0] n_scnt, n_fcnt;

  function automatic logic [VW-1:0] obs();
    return {bus.hold_pc_o_CTRL, bus.hold_ifid_o_CTRL, bus.hold_idex_o_CTRL,
            bus.flush_ifid_o_CTRL, bus.flush_idex_o_CTRL, bus.flush_exmem_o_CTRL,
            bus.jump_en_o_CTRL, bus.jump_addr_o_CTRL,
            bus.stall_cnt_o_CTRL, bus.flush_cnt_o_CTRL};
  endfunction

  // Predict this cycle's outputs from current requests; stage next model state.
  task automatic model_eval(output logic [VW-1:0] e);
    logic hp, hi, hx, fi, fx, fe, je;
    logic [31:0] a;
    {hp, hi, hx, fi, fx, fe, je} = 7'b0;
    a            = m_target;
    n_stalling   = m_stalling;
    n_flush_left = m_flush_left;
    n_target     = m_target;
    if (rst) begin
      a            = `CpuRstAddr;
      n_stalling   = 1'b0;
      n_flush_left = 0;
      n_target     = `CpuRstAddr;
    end else if (m_stalling) begin
      {hp, hi, hx, fe} = 4'b1111;
      if (bus.ex_done_i_CTRL) n_stalling = 1'b0;
    end else if (bus.jump_req_i_CTRL) begin
      {je, fi, fx} = 3'b111;
      a            = bus.jump_addr_i_CTRL;
      n_target     = bus.jump_addr_i_CTRL;
      n_flush_left = int'(FC) - 1;
    end else if (m_flush_left > 0) begin
      {fi, fx}     = 2'b11;
      n_flush_left = m_flush_left - 1;
    end else if (bus.ex_stallreq_i_CTRL) begin
      {hp, hi, hx, fe} = 4'b1111;
      n_stalling       = !bus.ex_done_i_CTRL;
    end else if (bus.id_stallreq_i_CTRL) begin
      {hp, hi, fx} = 3'b111;
    end
    n_scnt = m_scnt;
    n_fcnt = m_fcnt;
    if (rst) begin
      n_scnt = '0;
      n_fcnt = '0;
    end else if (PERF) begin
      if (hp && m_scnt != {CW{1'b1}}) n_scnt = m_scnt + 1;
      if (je && m_fcnt != {CW{1'b1}}) n_fcnt = m_fcnt + 1;
    end
    e = {hp, hi, hx, fi, fx, fe, je, a, m_scnt, m_fcnt};
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_stalling   = n_stalling;
    m_flush_left = n_flush_left;
    m_target     = n_target;
    m_scnt       = n_scnt;
    m_fcnt       = n_fcnt;
  endtask

  task automatic set_in(input bit id, input bit ex, input bit done, input bit jr,
                        input logic [31:0] ja);
    bus.id_stallreq_i_CTRL = id;
    bus.ex_stallreq_i_CTRL = ex;
    bus.ex_done_i_CTRL     = done;
    bus.jump_req_i_CTRL    = jr;
    bus.jump_addr_i_CTRL   = ja;
  endtask

  task automatic test_reset();
    logic [VW-1:0] e, o;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0);
    model_eval(e);
    advance();
    for (int c = 0; c < 7; c++) begin
      rst = (c < 1);
      model_eval(e);
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset c=%0d got=%h want=%h", c, o, e);
      end
      advance();
    end
    checks++;
    if (o[VW-1 -: 7] !== 7'b0) begin
      failures++;
      $display("FAIL reset_idle_controls got=%b want=0000000", o[VW-1 -: 7]);
    end
  endtask

  task automatic test_id_stall();
    logic [VW-1:0] e, o;
    int holds = 0;
    logic [CW-1:0] s0 = bus.stall_cnt_o_CTRL;
    for (int c = 0; c < 5; c++) begin
      set_in(c < 3, 0, 0, 0, 32'h0);
      model_eval(e);
      @(negedge clk);
      o = obs();
      if (bus.hold_pc_o_CTRL && bus.hold_ifid_o_CTRL && bus.flush_idex_o_CTRL) holds++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL id_stall c=%0d got=%h want=%h", c, o, e);
      end
      advance();
    end
    checks++;
    if (holds !== 3) begin
      failures++;
      $display("FAIL id_stall_len got=%0d want=3", holds);
    end
    checks++;
    if (bus.stall_cnt_o_CTRL - s0 !== (PERF ? CW'(3) : CW'(0))) begin
      failures++;
      $display("FAIL id_stall_cnt got=%0d want=%0d", bus.stall_cnt_o_CTRL - s0, PERF ? 3 : 0);
    end
  endtask

  // EX stall from cycle 0 to done at cycle 4 with id/jump raised meanwhile.
  task automatic test_ex_stall();
    logic [VW-1:0] e, o;
    int holds = 0, jumps_in_stall = 0;
    for (int c = 0; c < 9; c++) begin
      set_in(1, c == 0, c == 4, (c >= 1 && c <= 5), 32'h0000_0300);
      model_eval(e);
      @(negedge clk);
      o = obs();
      if (c <= 5 && bus.hold_pc_o_CTRL && bus.hold_idex_o_CTRL && bus.flush_exmem_o_CTRL) holds++;
      if (c <= 4 && bus.jump_en_o_CTRL) jumps_in_stall++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL ex_stall c=%0d got=%h want=%h", c, o, e);
      end
      advance();
    end
    checks++;
    if (holds !== 5 || jumps_in_stall !== 0) begin
      failures++;
      $display("FAIL ex_stall_len holds=%0d jumps=%0d want 5/0", holds, jumps_in_stall);
    end
    set_in(0, 0, 0, 0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      model_eval(e);
      advance();
    end
  endtask

  task automatic test_jump();
    logic [VW-1:0] e, o;
    int flushes = 0, jumps = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(c == 1, 0, 0, c == 0, 32'h0000_0100);
      model_eval(e);
      @(negedge clk);
      o = obs();
      flushes += int'(bus.flush_ifid_o_CTRL && bus.flush_idex_o_CTRL);
      jumps   += int'(bus.jump_en_o_CTRL);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL jump c=%0d got=%h want=%h", c, o, e);
      end
      advance();
    end
    checks++;
    if (flushes !== int'(FC) || jumps !== 1 || bus.jump_addr_o_CTRL !== 32'h100) begin
      failures++;
      $display("FAIL jump_window flushes=%0d jumps=%0d addr=%h want %0d/1/100",
               flushes, jumps, bus.jump_addr_o_CTRL, FC);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e, o;
    int flushes = 0, jumps = 0;
    logic [CW-1:0] f0 = bus.flush_cnt_o_CTRL;
    for (int c = 0; c < 7; c++) begin
      set_in(0, 0, 0, c < 2, (c == 0) ? 32'h0000_0100 : 32'h0000_0200);
      model_eval(e);
      @(negedge clk);
      o = obs();
      flushes += int'(bus.flush_ifid_o_CTRL);
      jumps   += int'(bus.jump_en_o_CTRL);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back c=%0d got=%h want=%h", c, o, e);
      end
      advance();
    end
    checks++;
    if (flushes !== int'(FC) + 1 || jumps !== 2 || bus.jump_addr_o_CTRL !== 32'h200) begin
      failures++;
      $display("FAIL b2b_window flushes=%0d jumps=%0d addr=%h want %0d/2/200",
               flushes, jumps, bus.jump_addr_o_CTRL, FC + 1);
    end
    checks++;
    if (bus.flush_cnt_o_CTRL - f0 !== (PERF ? CW'(2) : CW'(0))) begin
      failures++;
      $display("FAIL b2b_flush_cnt got=%0d want=%0d", bus.flush_cnt_o_CTRL - f0, PERF ? 2 : 0);
    end
  endtask

  // Reset lands in the middle of an EX stall; a later ex_done must be inert.
  task automatic test_reset_mid_stall();
    logic [VW-1:0] e, o;
    for (int c = 0; c < 7; c++) begin
      rst = (c == 2);
      set_in(0, c == 0, c == 4, 0, 32'h0);
      model_eval(e);
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid_stall c=%0d got=%h want=%h", c, o, e);
      end
      if (c == 3) begin
        checks++;
        if (o[VW-1 -: 7] !== 7'b0 || bus.stall_cnt_o_CTRL !== CW'(0)) begin
          failures++;
          $display("FAIL reset_mid_stall_post got=%b cnt=%0d want 0", o[VW-1 -: 7],
                   bus.stall_cnt_o_CTRL);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [VW-1:0] e, o;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) == 0);
      set_in($urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
             $urandom_range(5) == 0, {$urandom_range(32'hFFFF), 16'h0} | 32'($urandom_range(255) << 2));
      model_eval(e);
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random c=%0d got=%h want=%h", c, o, e);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_ex_stall();
    test_jump();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
